// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential signed divider
package div_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;
    localparam int ITER       = 32;

    localparam logic [DIVIDEND_W-1:0] DIV_ZERO_Q = '0;
    localparam logic [DIVIDEND_W-1:0] OVF_Q      = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FIX
    } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - combinational conditional two's-complement negation
module div_sign_fix #(
    parameter int W = 16
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    // Used both as |x| (negate = sign bit) and to re-apply result signs.
    assign result = negate ? ((~value) + W'(1)) : value;

endmodule

// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - 32/16 signed radix-2 restoring divider with Start/Done handshake
module seq_signed_divider
    import div_pkg::*;
(
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [DIVIDEND_W-1:0] Dividend,
    input  logic [DIVISOR_W-1:0]  Divisor,
    output logic [DIVIDEND_W-1:0] Quotient,
    output logic [DIVISOR_W-1:0]  Remainder,
    output logic                  Busy,
    output logic                  Done,
    output logic                  DivByZero,
    output logic                  Overflow
);

    div_state_t            state;
    logic [DIVISOR_W:0]    prem;
    logic [DIVIDEND_W-1:0] qreg;
    logic [DIVISOR_W-1:0]  dvs_mag;
    logic [4:0]            cnt;
    logic                  sign_n;
    logic                  sign_d;

    logic [DIVIDEND_W-1:0] dividend_mag;
    logic [DIVISOR_W-1:0]  divisor_mag;
    logic [DIVIDEND_W-1:0] q_signed;
    logic [DIVISOR_W-1:0]  r_signed;
    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W+1:0]  trial;
    logic                  no_borrow;
    logic                  q_negative;

    div_sign_fix #(.W(DIVIDEND_W)) u_abs_dividend (
        .value  (Dividend),
        .negate (Dividend[DIVIDEND_W-1]),
        .result (dividend_mag)
    );

    div_sign_fix #(.W(DIVISOR_W)) u_abs_divisor (
        .value  (Divisor),
        .negate (Divisor[DIVISOR_W-1]),
        .result (divisor_mag)
    );

    assign q_negative = sign_n ^ sign_d;

    div_sign_fix #(.W(DIVIDEND_W)) u_fix_quotient (
        .value  (qreg),
        .negate (q_negative),
        .result (q_signed)
    );

    // Remainder magnitude is always below 2^15, so the top partial-remainder bit is dropped.
    div_sign_fix #(.W(DIVISOR_W)) u_fix_remainder (
        .value  (prem[DIVISOR_W-1:0]),
        .negate (sign_n),
        .result (r_signed)
    );

    assign shifted   = {prem[DIVISOR_W-1:0], qreg[DIVIDEND_W-1]};
    assign trial     = {1'b0, shifted} - {2'b00, dvs_mag};
    assign no_borrow = ~trial[DIVISOR_W+1];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            prem      <= '0;
            qreg      <= '0;
            dvs_mag   <= '0;
            cnt       <= '0;
            sign_n    <= 1'b0;
            sign_d    <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        qreg    <= dividend_mag;
                        dvs_mag <= divisor_mag;
                        sign_n  <= Dividend[DIVIDEND_W-1];
                        sign_d  <= Divisor[DIVISOR_W-1];
                        prem    <= '0;
                        cnt     <= '0;
                        Busy    <= 1'b1;
                        state   <= (Divisor == '0) ? FIX : DIVIDE;
                    end
                end
                DIVIDE: begin
                    prem <= no_borrow ? trial[DIVISOR_W:0] : shifted;
                    qreg <= {qreg[DIVIDEND_W-2:0], no_borrow};
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'(ITER - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    state <= IDLE;
                    if (dvs_mag == '0) begin
                        Quotient  <= DIV_ZERO_Q;
                        Remainder <= '0;
                        DivByZero <= 1'b1;
                        Overflow  <= 1'b0;
                    end else if (!q_negative && qreg[DIVIDEND_W-1]) begin
                        // Only -2^31 / -1 yields a positive magnitude of 2^31.
                        Quotient  <= OVF_Q;
                        Remainder <= '0;
                        DivByZero <= 1'b0;
                        Overflow  <= 1'b1;
                    end else begin
                        Quotient  <= q_signed;
                        Remainder <= r_signed;
                        DivByZero <= 1'b0;
                        Overflow  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - randomized self-checking bench for seq_signed_divider
module tb_seq_signed_divider;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [31:0] Dividend;
    logic [15:0] Divisor;
    logic [31:0] Quotient;
    logic [15:0] Remainder;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic        Overflow;

    int          n_vec;
    int          n_err;
    logic [31:0] last_q;

    seq_signed_divider dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .Overflow  (Overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed arithmetic on wide integers plus the exception rules.
    function automatic void ref_div(input logic [31:0] a, input logic [15:0] b,
                                    output logic [31:0] q, output logic [15:0] r,
                                    output logic z, output logic o);
        longint da, db, eq, er;
        da = longint'($signed(a));
        db = longint'($signed(b));
        if (db == 0) begin
            q = 32'd0; r = 16'd0; z = 1'b1; o = 1'b0;
        end else begin
            eq = da / db;
            er = da % db;
            q  = eq[31:0];
            r  = er[15:0];
            z  = 1'b0;
            o  = (da == -64'sd2147483648) && (db == -64'sd1);
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [15:0] b);
        logic [31:0] xq;
        logic [15:0] xr;
        logic        xz, xo;
        int          lat, exp_lat;
        bit          seen;
        ref_div(a, b, xq, xr, xz, xo);
        exp_lat = xz ? 1 : 33;
        @(negedge Clock);
        Start = 1'b1; Dividend = a; Divisor = b;
        @(posedge Clock); #1;
        Start = 1'b0; Dividend = $urandom; Divisor = 16'($urandom);
        check("busy_on_accept", 64'(Busy), 64'd1);
        check("q_hold_on_accept", 64'(Quotient), 64'(last_q));
        seen = 1'b0; lat = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(posedge Clock); #1;
            if (Done) begin seen = 1'b1; lat = c; end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("latency", 64'(lat), 64'(exp_lat));
        check("busy_clear_with_done", 64'(Busy), 64'd0);
        check("quotient", 64'(Quotient), 64'(xq));
        check("remainder", 64'(Remainder), 64'(xr));
        check("div_by_zero", 64'(DivByZero), 64'(xz));
        check("overflow", 64'(Overflow), 64'(xo));
        @(posedge Clock); #1;
        check("done_one_cycle", 64'(Done), 64'd0);
        last_q = xq;
    endtask

    task automatic round_trip(input logic [15:0] mcand, input logic [15:0] mplier);
        longint prod;
        prod = longint'($signed(mcand)) * longint'($signed(mplier));
        run_op(prod[31:0], mcand);
        check("rt_quotient", 64'(Quotient), 64'(longint'($signed(mplier))) & 64'hffff_ffff);
        check("rt_remainder", 64'(Remainder), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, xq;
        logic [15:0] rb, xr;
        logic        xz, xo;
        int          dones;
        n_vec = 0; n_err = 0; last_q = 32'd0;
        Reset = 1'b0; Start = 1'b0; Dividend = 32'd0; Divisor = 16'd0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_quotient", 64'(Quotient), 64'd0);
        check("rst_remainder", 64'(Remainder), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_dbz", 64'(DivByZero), 64'd0);
        check("rst_ovf", 64'(Overflow), 64'd0);
        @(negedge Clock); Reset = 1'b1;

        run_op(32'd120, 16'd12);
        run_op(-32'sd125, 16'd12);
        run_op(32'd125, -16'sd12);
        run_op(-32'sd125, -16'sd12);
        run_op(32'h8000_0000, 16'hffff);
        run_op(32'd1000, 16'd0);

        round_trip(-16'sd12, 16'd10);
        round_trip(-16'sd32768, -16'sd32768);
        round_trip(-16'sd12345, -16'sd23456);

        // A second Start at E10 must not disturb the running operation.
        ref_div(32'd1000000, -16'sd77, xq, xr, xz, xo);
        @(negedge Clock);
        Start = 1'b1; Dividend = 32'd1000000; Divisor = -16'sd77;
        @(posedge Clock); #1;
        Start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 10) begin Start = 1'b1; Dividend = 32'd99; Divisor = 16'd3; end
            if (c == 11) Start = 1'b0;
            @(posedge Clock); #1;
            if (Done) begin
                dones++;
                check("ignore_quotient", 64'(Quotient), 64'(xq));
                check("ignore_remainder", 64'(Remainder), 64'(xr));
            end
        end
        check("ignore_done_count", 64'(dones), 64'd1);
        last_q = xq;

        // Reset mid-operation abandons it without a Done.
        @(negedge Clock);
        Start = 1'b1; Dividend = 32'd1000; Divisor = 16'd7;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (15) @(posedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        check("midrst_quotient", 64'(Quotient), 64'd0);
        check("midrst_remainder", 64'(Remainder), 64'd0);
        check("midrst_busy", 64'(Busy), 64'd0);
        check("midrst_done", 64'(Done), 64'd0);
        check("midrst_dbz", 64'(DivByZero), 64'd0);
        check("midrst_ovf", 64'(Overflow), 64'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge Clock); #1;
            if (Done) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'd0);
        last_q = 32'd0;
        run_op(32'd7, 16'd2);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 16'd0;
                1: rb = 16'hffff;
                2: rb = 16'h8000;
                3: ra = 32'h8000_0000;
                4: rb = 16'($urandom_range(1, 300));
                5: rb = -16'($urandom_range(1, 300));
                default: ;
            endcase
            run_op(ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
